// File: rtl/act_broadcast_arbiter.sv
// act_broadcast_arbiter: round-robin arbiter sharing one registered activation broadcast bus among NUM_PE sources for a layer
// ports: start_broadcast starts a layer; req/req_idx/req_data/src_done from PEs; queue_full back-pressure;
//        grant pops PE k (combinational); bcast_* registered bus; fin_broadcast end pulse; busy, bcast_count, start_err status
module act_broadcast_arbiter #(
  parameter int NUM_PE     = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_broadcast,
  input  logic [NUM_PE-1:0]            req,
  input  logic [NUM_PE*ADDR_WIDTH-1:0] req_idx,
  input  logic [NUM_PE*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_PE-1:0]            src_done,
  input  logic                         queue_full,
  output logic [NUM_PE-1:0]            grant,
  output logic                         bcast_valid,
  output logic [ADDR_WIDTH-1:0]        bcast_idx,
  output logic [DATA_WIDTH-1:0]        bcast_data,
  output logic                         fin_broadcast,
  output logic                         busy,
  output logic [CNT_WIDTH-1:0]         bcast_count,
  output logic                         start_err
);
  localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  typedef enum logic [1:0] {IDLE, ARB, FIN} state_t;
  state_t state;
  logic [PW-1:0] rr_ptr, sel, cand;
  logic found, exit_c, gnt_en;
  // descending offset scan: the last hit, i.e. the smallest offset from rr_ptr, wins
  always_comb begin
    sel = '0;
    cand = '0;
    found = 1'b0;
    for (int i = NUM_PE - 1; i >= 0; i--) begin
      cand = rr_ptr + PW'(i);
      if (req[cand]) begin
        sel = cand;
        found = 1'b1;
      end
    end
  end
  assign exit_c = ~|req & &src_done;
  assign gnt_en = (state == ARB) && !queue_full && found;
  assign grant = gnt_en ? NUM_PE'(1) << sel : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      bcast_valid <= 1'b0;
      bcast_idx <= '0;
      bcast_data <= '0;
      fin_broadcast <= 1'b0;
      busy <= 1'b0;
      bcast_count <= '0;
      start_err <= 1'b0;
    end else begin
      fin_broadcast <= 1'b0;
      bcast_valid <= 1'b0;
      if (start_broadcast && state != IDLE) start_err <= 1'b1;
      case (state)
        IDLE: if (start_broadcast) begin
          state <= ARB;
          busy <= 1'b1;
          rr_ptr <= '0;
          bcast_count <= '0;
        end
        ARB: if (exit_c) begin
          state <= FIN;
          fin_broadcast <= 1'b1;
        end else if (gnt_en) begin
          bcast_valid <= 1'b1;
          bcast_idx <= req_idx[sel*ADDR_WIDTH +: ADDR_WIDTH];
          bcast_data <= req_data[sel*DATA_WIDTH +: DATA_WIDTH];
          rr_ptr <= sel + PW'(1);
          bcast_count <= &bcast_count ? bcast_count : bcast_count + CNT_WIDTH'(1);
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_act_broadcast_arbiter.sv
// tb_act_broadcast_arbiter: directed scoreboard bench for act_broadcast_arbiter
module tb_act_broadcast_arbiter;
  localparam int NP = 8, AW = 12, DW = 16, CW = 4;
  logic clk = 1'b0, rst_n = 1'b0, start_broadcast = 1'b0, queue_full = 1'b0;
  logic [NP-1:0] req = '0, src_done = '1;
  logic [NP*AW-1:0] req_idx = '0;
  logic [NP*DW-1:0] req_data = '0;
  logic [NP-1:0] grant;
  logic bcast_valid, fin_broadcast, busy, start_err;
  logic [AW-1:0] bcast_idx;
  logic [DW-1:0] bcast_data;
  logic [CW-1:0] bcast_count;

  act_broadcast_arbiter #(.NUM_PE(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start_broadcast(start_broadcast), .req(req), .req_idx(req_idx),
    .req_data(req_data), .src_done(src_done), .queue_full(queue_full), .grant(grant),
    .bcast_valid(bcast_valid), .bcast_idx(bcast_idx), .bcast_data(bcast_data),
    .fin_broadcast(fin_broadcast), .busy(busy), .bcast_count(bcast_count), .start_err(start_err));

  always #5 clk = ~clk;

  typedef struct packed {logic [AW-1:0] idx; logic [DW-1:0] data;} word_t;
  word_t sb[$];
  int cnt[NP], seqn[NP];
  int pass_cnt = 0, fail_cnt = 0, total = 0;
  int cyc = 0, fin_cyc = -1, words = 0, gk = -1, c0 = 0;
  int glog[$], gcyc[$];
  logic last_v, last_b;
  logic [NP-1:0] last_g;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    if (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic word_t mk(int k, int n);
    word_t w;
    w.idx = AW'((n << 3) | k);
    w.data = DW'(k * 4096 + n * 17 + 5);
    return w;
  endfunction

  task automatic apply_src();
    word_t w;
    for (int k = 0; k < NP; k++) begin
      w = mk(k, seqn[k]);
      req[k] = cnt[k] > 0;
      req_idx[k*AW +: AW] = w.idx;
      req_data[k*DW +: DW] = w.data;
    end
  endtask

  task automatic check_cycle();
    word_t e;
    last_v = bcast_valid;
    last_g = grant;
    last_b = busy;
    gk = -1;
    if (bcast_valid) begin
      chk("sb_nonempty", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("bcast_idx", bcast_idx, e.idx);
        chk("bcast_data", bcast_data, e.data);
        words++;
      end
    end
    chk("grant_onehot0", $onehot0(grant), 1'b1);
    if (grant != 0) begin
      for (int k = 0; k < NP; k++) if (grant[k]) gk = k;
      chk("grant_has_req", cnt[gk] > 0, 1'b1);
      sb.push_back(mk(gk, seqn[gk]));
      glog.push_back(gk);
      gcyc.push_back(cyc);
    end
    if (fin_broadcast) begin
      chk("fin_once", fin_cyc, -1);
      fin_cyc = cyc;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    if (gk >= 0) begin
      cnt[gk]--;
      seqn[gk]++;
    end
    apply_src();
    cyc++;
  endtask

  task automatic new_layer();
    glog.delete();
    gcyc.delete();
    fin_cyc = -1;
    words = 0;
  endtask

  task automatic load(int k, int n);
    cnt[k] = n;
    seqn[k] = 0;
  endtask

  task automatic start();
    apply_src();
    new_layer();
    start_broadcast = 1'b1;
    c0 = cyc;
    tick();
    start_broadcast = 1'b0;
  endtask

  task automatic run(int budget);
    for (int i = 0; i < budget && fin_cyc < 0; i++) tick();
    chk("fin_seen", fin_cyc >= 0, 1'b1);
  endtask

  initial begin
    for (int k = 0; k < NP; k++) load(k, 0);
    apply_src();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_valid", bcast_valid, 1'b0);
    chk("rst_idx", bcast_idx, 0);
    chk("rst_data", bcast_data, 0);
    chk("rst_fin", fin_broadcast, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", bcast_count, 0);
    chk("rst_err", start_err, 1'b0);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 4; k++) load(k, 2);
    start();
    chk("t1_idle_busy_c0", last_b, 1'b0);
    tick();
    chk("t1_busy_c1", last_b, 1'b1);
    run(40);
    chk("t1_ngrants", glog.size(), 8);
    for (int i = 0; i < 8 && i < glog.size(); i++) begin
      chk("t1_order", glog[i], i % 4);
      chk("t1_cycle", gcyc[i], c0 + 1 + i);
    end
    chk("t1_fin_cyc", fin_cyc, c0 + 10);
    tick();
    chk("t1_busy_after", last_b, 1'b0);
    chk("t1_count", bcast_count, 8);
    chk("t1_words", words, 8);
    chk("t1_sb_empty", sb.size(), 0);

    load(2, 3);
    load(5, 3);
    start();
    run(40);
    chk("t2_ngrants", glog.size(), 6);
    for (int i = 0; i < 6 && i < glog.size(); i++) chk("t2_order", glog[i], (i % 2) ? 5 : 2);
    chk("t2_count", bcast_count, 6);
    chk("t2_words", words, 6);

    for (int k = 0; k < 4; k++) load(k, 3);
    start();
    repeat (3) tick();
    queue_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_bp_grant", last_g, 0);
      chk("t3_bp_valid", last_v, i == 0);
    end
    queue_full = 1'b0;
    run(60);
    chk("t3_ngrants", glog.size(), 12);
    for (int i = 0; i < 12 && i < glog.size(); i++) chk("t3_order", glog[i], i % 4);
    if (glog.size() > 3) chk("t3_resume_cyc", gcyc[3], c0 + 9);
    chk("t3_count", bcast_count, 12);
    chk("t3_words", words, 12);
    chk("t3_sb_empty", sb.size(), 0);

    for (int k = 0; k < NP; k++) load(k, 3);
    start();
    run(80);
    chk("t4_sat_count", bcast_count, 4'hF);
    chk("t4_words", words, 24);

    start();
    run(10);
    chk("t5_fin_cyc", fin_cyc, c0 + 2);
    chk("t5_count", bcast_count, 0);
    chk("t5_words", words, 0);

    load(0, 2);
    load(1, 2);
    start();
    tick();
    start_broadcast = 1'b1;
    tick();
    start_broadcast = 1'b0;
    run(30);
    chk("t6_start_err", start_err, 1'b1);
    chk("t6_ngrants", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++) chk("t6_order", glog[i], i % 2);
    chk("t6_count", bcast_count, 4);
    tick();
    chk("t6_err_sticky", start_err, 1'b1);

    for (int k = 0; k < 5; k++) load(k, 2);
    start();
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("t7_grant", grant, 0);
    chk("t7_valid", bcast_valid, 1'b0);
    chk("t7_idx", bcast_idx, 0);
    chk("t7_data", bcast_data, 0);
    chk("t7_busy", busy, 1'b0);
    chk("t7_count", bcast_count, 0);
    chk("t7_err", start_err, 1'b0);
    sb.delete();
    for (int k = 0; k < NP; k++) load(k, 0);
    apply_src();
    repeat (3) tick();
    rst_n = 1'b1;
    chk("t7_no_fin", fin_cyc, -1);
    load(1, 1);
    load(3, 1);
    start();
    run(20);
    chk("t7_ngrants", glog.size(), 2);
    for (int i = 0; i < 2 && i < glog.size(); i++) chk("t7_order", glog[i], i ? 3 : 1);
    chk("t7_count2", bcast_count, 2);
    chk("t7_err2", start_err, 1'b0);
    chk("t7_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
